// File: rtl/video_fetch_sequencer.sv
// rtl/video_fetch_sequencer.sv - per-line video byte prefetch and shift-register load sequencer
module video_fetch_sequencer #(
  parameter int BYTES_PER_LINE = 32,
  parameter int ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frameStart,
  input  logic              lineStart,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic              div2,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [7:0]        memData,
  output logic              load,
  output logic [7:0]        data,
  output logic              active,
  output logic              underrun
);

  typedef enum logic [1:0] {IDLE, FETCH, ACTIVE, FLUSH} state_t;

  localparam logic [7:0]        LINE_BYTES = 8'(BYTES_PER_LINE);
  localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(BYTES_PER_LINE);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  state_t            state, stateNxt;
  logic [ADDR_W-1:0] lineBase, lineBaseNxt, addr, addrNxt, memAddrNxt, baseNow;
  logic [7:0]        bufData, bufDataNxt, dataNxt;
  logic [7:0]        loadsLeft, loadsLeftNxt, fetchesLeft, fetchesLeftNxt;
  logic [2:0]        slotCnt, slotCntNxt, slotMax;
  logic              bufValid, bufValidNxt, stale, staleNxt;
  logic              memReqNxt, loadNxt, activeNxt, underrunNxt, slotEnd;

  // Next-state, fetch handshake and load-slot decisions; all outputs are registered from these
  always_comb begin
    stateNxt       = state;
    lineBaseNxt    = lineBase;
    addrNxt        = addr;
    bufDataNxt     = bufData;
    bufValidNxt    = bufValid;
    slotCntNxt     = slotCnt;
    loadsLeftNxt   = loadsLeft;
    fetchesLeftNxt = fetchesLeft;
    staleNxt       = stale;
    memReqNxt      = memReq;
    memAddrNxt     = memAddr;
    loadNxt        = 1'b0;
    dataNxt        = data;
    underrunNxt    = underrun;
    activeNxt      = (state != IDLE);
    slotMax        = div2 ? 3'd7 : 3'd3;
    slotEnd        = (slotCnt == slotMax);
    baseNow        = frameStart ? baseAddr : lineBase;

    if (frameStart) begin
      lineBaseNxt = baseAddr;
      underrunNxt = 1'b0;
    end

    if (lineStart) begin
      // An unacked request belongs to the aborted line: keep the handshake, drop its byte
      addrNxt        = baseNow;
      lineBaseNxt    = baseNow + LINE_STEP;
      bufValidNxt    = 1'b0;
      loadsLeftNxt   = LINE_BYTES;
      fetchesLeftNxt = LINE_BYTES;
      stateNxt       = FETCH;
      activeNxt      = 1'b1;
      staleNxt       = memReq && !memAck;
    end else begin
      case (state)
        FETCH: begin
          if (bufValid) begin
            loadNxt      = 1'b1;
            dataNxt      = bufData;
            bufValidNxt  = 1'b0;
            loadsLeftNxt = loadsLeft - 8'd1;
            slotCntNxt   = 3'd0;
            stateNxt     = (loadsLeft == 8'd1) ? FLUSH : ACTIVE;
          end
        end
        ACTIVE: begin
          if (slotEnd) begin
            loadNxt      = 1'b1;
            slotCntNxt   = 3'd0;
            loadsLeftNxt = loadsLeft - 8'd1;
            if (bufValid) begin
              dataNxt     = bufData;
              bufValidNxt = 1'b0;
            end else begin
              dataNxt     = 8'h00;
              underrunNxt = 1'b1;
            end
            if (loadsLeft == 8'd1) stateNxt = FLUSH;
          end else begin
            slotCntNxt = slotCnt + 3'd1;
          end
        end
        FLUSH: begin
          if (slotEnd) begin
            loadNxt    = 1'b1;
            dataNxt    = 8'h00;
            slotCntNxt = 3'd0;
            stateNxt   = IDLE;
          end else begin
            slotCntNxt = slotCnt + 3'd1;
          end
        end
        default: ;
      endcase

      // Fetch completion lands after the slot decision so a same-cycle ack refills the buffer
      if (memReq && memAck) begin
        if (stale) begin
          staleNxt = 1'b0;
        end else begin
          bufDataNxt     = memData;
          bufValidNxt    = 1'b1;
          addrNxt        = addr + ADDR_ONE;
          fetchesLeftNxt = fetchesLeft - 8'd1;
        end
      end
    end

    if (memReq) begin
      memReqNxt = !memAck;
    end else begin
      memReqNxt  = (stateNxt != IDLE) && !bufValidNxt && (fetchesLeftNxt != 8'd0);
      memAddrNxt = addrNxt;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lineBase    <= '0;
      addr        <= '0;
      bufData     <= 8'h00;
      bufValid    <= 1'b0;
      slotCnt     <= 3'd0;
      loadsLeft   <= 8'd0;
      fetchesLeft <= 8'd0;
      stale       <= 1'b0;
      memReq      <= 1'b0;
      memAddr     <= '0;
      load        <= 1'b0;
      data        <= 8'h00;
      active      <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= stateNxt;
      lineBase    <= lineBaseNxt;
      addr        <= addrNxt;
      bufData     <= bufDataNxt;
      bufValid    <= bufValidNxt;
      slotCnt     <= slotCntNxt;
      loadsLeft   <= loadsLeftNxt;
      fetchesLeft <= fetchesLeftNxt;
      stale       <= staleNxt;
      memReq      <= memReqNxt;
      memAddr     <= memAddrNxt;
      load        <= loadNxt;
      data        <= dataNxt;
      active      <= activeNxt;
      underrun    <= underrunNxt;
    end
  end

endmodule

// File: tb/tb_video_fetch_sequencer.sv
// tb/tb_video_fetch_sequencer.sv - randomized line sequencing bench with a slot-level reference model
module tb_video_fetch_sequencer;

  localparam int BPL = 32;

  logic        clk = 1'b0;
  logic        reset, frameStart, lineStart, div2, memAck, load, active, underrun, memReq;
  logic [15:0] baseAddr, memAddr;
  logic [7:0]  memData, data;

  video_fetch_sequencer #(.BYTES_PER_LINE(BPL), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .frameStart(frameStart), .lineStart(lineStart),
    .baseAddr(baseAddr), .div2(div2), .memReq(memReq), .memAddr(memAddr),
    .memAck(memAck), .memData(memData), .load(load), .data(data),
    .active(active), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [7:0] d;
  } fetch_t;

  fetch_t      pend[$];
  int          cyc, nChk, nFail;
  int          loadsSeen, lastLoad, firstAck, fetched, period;
  int          age, curDly, dlyLo, dlyHi, actCount, prevAddr;
  logic [15:0] lbm, expAddr;
  bit          activeM, undM, staleM, lineUnder, rstSeen;
  bit          undClearNext, activeSetNext, activeClearNext, reqExpNext, prevHold;

  task automatic expect_eq(input string tag, input int got, input int want);
    nChk++;
    if (got != want) begin
      nFail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, want, want, cyc);
    end
  endtask

  // Video memory contents: never zero, so a 0x00 load is always a blank
  function automatic logic [7:0] memf(input logic [15:0] a);
    logic [15:0] h;
    h = a * 16'd40503 + 16'd12345;
    return (h[15:8] == 8'h00) ? 8'h5a : h[15:8];
  endfunction

  // One clock: observe at negedge, check against model, answer memory, drive next inputs
  task automatic tick(input bit fs, input bit ls, input bit rst);
    bit         ackNow;
    fetch_t     b;
    logic [7:0] expD;
    @(negedge clk);
    cyc++;
    if (rstSeen) begin
      expect_eq("reset_memReq", int'(memReq), 0);
      expect_eq("reset_memAddr", int'(memAddr), 0);
      expect_eq("reset_load", int'(load), 0);
      expect_eq("reset_data", int'(data), 0);
      expect_eq("reset_active", int'(active), 0);
      expect_eq("reset_underrun", int'(underrun), 0);
      lbm = 16'h0000; loadsSeen = BPL + 1; pend.delete();
      activeM = 0; undM = 0; staleM = 0; age = 0; prevHold = 0;
      undClearNext = 0; activeSetNext = 0; activeClearNext = 0; reqExpNext = 0;
      rstSeen = 0;
    end
    if (undClearNext) undM = 0;
    if (activeClearNext) activeM = 0;
    if (activeSetNext) activeM = 1;
    undClearNext = 0; activeClearNext = 0; activeSetNext = 0;
    if (reqExpNext) expect_eq("req_after_line_start", int'(memReq), 1);
    reqExpNext = 0;
    if (prevHold) begin
      expect_eq("req_held_until_ack", int'(memReq), 1);
      expect_eq("addr_stable", int'(memAddr), prevAddr);
    end
    if (load) begin
      if (loadsSeen < BPL) begin
        expect_eq("load_time", cyc, (loadsSeen == 0) ? firstAck + 2 : lastLoad + period);
        if (pend.size() > 0 && pend[0].c <= cyc - 2) begin
          b = pend.pop_front();
          expD = b.d;
        end else begin
          expD = 8'h00; undM = 1; lineUnder = 1;
        end
        expect_eq("load_data", int'(data), int'(expD));
      end else if (loadsSeen == BPL) begin
        expect_eq("flush_time", cyc, lastLoad + period);
        expect_eq("flush_data", int'(data), 0);
        activeClearNext = 1;
      end else begin
        expect_eq("unexpected_load", loadsSeen, BPL);
      end
      lastLoad = cyc;
      loadsSeen++;
    end
    expect_eq("active", int'(active), int'(activeM));
    expect_eq("underrun", int'(underrun), int'(undM));
    if (active) actCount++;

    ackNow = 0;
    if (!memReq) age = 0;
    else if (!memAck) begin
      age++;
      if (age == 1) curDly = $urandom_range(dlyHi, dlyLo);
      if (age >= curDly + 2) ackNow = 1;
    end
    prevHold = memReq && !ackNow && !rst;
    prevAddr = int'(memAddr);
    if (ackNow) begin
      memAck = 1'b1; memData = memf(memAddr); age = 0;
      if (staleM) staleM = 0;
      else begin
        expect_eq("fetch_addr", int'(memAddr), int'(expAddr));
        expAddr = expAddr + 16'd1;
        fetched++;
        if (fetched == 1) firstAck = cyc;
        expect_eq("fetch_within_line", int'(fetched <= BPL), 1);
        b.c = cyc; b.d = memData;
        pend.push_back(b);
      end
    end else begin
      memAck = 1'b0; memData = 8'($urandom);
    end

    frameStart = fs; lineStart = ls; reset = rst;
    if (fs) begin
      lbm = baseAddr; undClearNext = 1;
    end
    if (ls) begin
      expAddr = lbm; lbm = lbm + 16'(BPL);
      pend.delete(); loadsSeen = 0; fetched = 0; firstAck = -1000; lineUnder = 0;
      staleM = memReq && !ackNow; activeSetNext = 1; reqExpNext = !memReq;
    end
    if (rst) rstSeen = 1;
  endtask

  task automatic run_line(input bit fs, input logic [15:0] base, input bit d2,
                          input int lo, input int hi, input int abortAfter);
    int n;
    baseAddr = base; div2 = d2; dlyLo = lo; dlyHi = hi;
    period = d2 ? 8 : 4;
    actCount = 0;
    tick(fs, 1, 0);
    if (abortAfter > 0) begin
      n = 0;
      while (!(loadsSeen >= abortAfter && memReq) && n < 3000) begin
        tick(0, 0, 0); n++;
      end
      expect_eq("abort_point_reached", int'(n < 3000), 1);
      tick(0, 1, 0);
    end
    n = 0;
    while (!(loadsSeen == BPL + 1 && !activeM && !memReq) && n < 5000) begin
      tick(0, 0, 0); n++;
    end
    expect_eq("line_done", int'(n < 5000), 1);
    if (!lineUnder) expect_eq("fetch_total", fetched, BPL);
    if (hi == 0 && abortAfter == 0) expect_eq("active_cycles", actCount, BPL * period + 4);
    repeat (3) tick(0, 0, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; frameStart = 1'b0; lineStart = 1'b0; baseAddr = 16'h0000;
    div2 = 1'b0; memAck = 1'b0; memData = 8'h00;
    cyc = 0; nChk = 0; nFail = 0; loadsSeen = BPL + 1; lastLoad = 0; firstAck = -1000;
    fetched = 0; period = 4; age = 0; curDly = 0; dlyLo = 0; dlyHi = 0; actCount = 0;
    prevAddr = 0; lbm = 16'h0000; expAddr = 16'h0000;
    activeM = 0; undM = 0; staleM = 0; lineUnder = 0; rstSeen = 0;
    undClearNext = 0; activeSetNext = 0; activeClearNext = 0; reqExpNext = 0; prevHold = 0;
    repeat (2) @(posedge clk);
    tick(0, 0, 1);
    tick(0, 0, 0);

    run_line(1, 16'h0400, 0, 0, 0, 0);
    run_line(1, 16'h0400, 1, 0, 0, 0);
    run_line(0, 16'h0000, 0, 0, 0, 0);
    baseAddr = 16'h0400;
    tick(1, 0, 0);
    run_line(0, 16'h0400, 0, 0, 0, 0);

    run_line(0, 16'h0000, 0, 6, 6, 0);
    expect_eq("underrun_exercised", int'(lineUnder), 1);
    repeat (5) tick(0, 0, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);

    run_line(0, 16'h0000, 0, 4, 4, 3);

    for (int i = 0; i < 6; i++) begin
      run_line(1'($urandom_range(1, 0)), 16'($urandom), 1'($urandom_range(1, 0)),
               0, $urandom_range(5, 0),
               ($urandom_range(3, 0) == 0) ? $urandom_range(8, 2) : 0);
    end

    baseAddr = 16'h1234; div2 = 1'b0; dlyLo = 0; dlyHi = 0; period = 4;
    tick(1, 1, 0);
    n = 0;
    while (loadsSeen < 5 && n < 1000) begin
      tick(0, 0, 0); n++;
    end
    expect_eq("reached_active", int'(n < 1000), 1);
    tick(0, 0, 1);
    tick(0, 0, 0);
    run_line(0, 16'hffff, 0, 0, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nChk, nFail);
    $finish;
  end

endmodule
